// File: rtl/tmds_decoder_if.sv
// Channel-side bundle of one TMDS decoder: raw deserialized word in, decoded
// pixel/control stream, lock status and bit-slip request out.
interface tmds_decoder_if;
    logic [9:0] tmds_in;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       valid_out;
    logic       locked_out;
    logic       bitslip_out;

    modport master (
        output tmds_in,
        input  data_out, control_out, ve_out, valid_out, locked_out, bitslip_out
    );

    modport slave (
        input  tmds_in,
        output data_out, control_out, ve_out, valid_out, locked_out, bitslip_out
    );
endinterface

// File: rtl/tmds_decoder.sv
// One-channel TMDS receiver: word alignment by control-token search with
// deserializer bit-slip requests, then 10b->8b decode in a two-stage pipeline.
module tmds_decoder #(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    tmds_decoder_if.slave bus
);

    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int TO_W   = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SLIP_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(TOKEN_RUN);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SEARCH_TIMEOUT - 1);
    // SLIP always lasts at least one cycle so bitslip can never pulse back-to-back.
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        SLIP,
        LOCKED
    } state_t;

    logic             in_is_token;
    logic [1:0]       in_token_val;

    logic [9:0]       word_reg;
    logic             is_token_reg;
    logic [1:0]       token_val_reg;

    logic [7:0]       d_word;
    logic [7:0]       dec_next;

    logic [7:0]       data_reg;
    logic [1:0]       control_reg;
    logic             ve_reg;

    state_t           state_reg, state_next;
    logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
    logic [TO_W-1:0]  timeout_cnt_reg, timeout_cnt_next;
    logic [SLIP_W-1:0] slip_cnt_reg, slip_cnt_next;
    logic             bitslip_reg, bitslip_next;
    logic             locked_reg, locked_next;

    always_comb begin
        in_is_token  = 1'b1;
        in_token_val = 2'b00;
        case (bus.tmds_in)
            10'b1101010100: in_token_val = 2'b00;
            10'b0010101011: in_token_val = 2'b01;
            10'b0101010100: in_token_val = 2'b10;
            10'b1010101011: in_token_val = 2'b11;
            default:        in_is_token  = 1'b0;
        endcase
    end

    // Stage 1: raw word and its token classification.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            word_reg      <= '0;
            is_token_reg  <= 1'b0;
            token_val_reg <= 2'b00;
        end else begin
            word_reg      <= bus.tmds_in;
            is_token_reg  <= in_is_token;
            token_val_reg <= in_token_val;
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign d_word      = word_reg[9] ? ~word_reg[7:0] : word_reg[7:0];
    assign dec_next[0] = d_word[0];

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_next[gi] = word_reg[8] ? (d_word[gi] ^ d_word[gi-1])
                                              : ~(d_word[gi] ^ d_word[gi-1]);
        end
    endgenerate

    // Stage 2: control value is sticky across data words.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_reg    <= '0;
            control_reg <= 2'b00;
            ve_reg      <= 1'b0;
        end else if (is_token_reg) begin
            data_reg    <= '0;
            control_reg <= token_val_reg;
            ve_reg      <= 1'b0;
        end else begin
            data_reg    <= dec_next;
            ve_reg      <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg       <= SEARCH;
            run_cnt_reg     <= '0;
            timeout_cnt_reg <= '0;
            slip_cnt_reg    <= '0;
            bitslip_reg     <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_cnt_reg     <= run_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            slip_cnt_reg    <= slip_cnt_next;
            bitslip_reg     <= bitslip_next;
            locked_reg      <= locked_next;
        end
    end

    // The FSM judges the word entering stage 1, so slip and lock loss line up
    // with stage 1 while lock gain is held back one cycle to match stage 2.
    always_comb begin
        state_next       = state_reg;
        run_cnt_next     = run_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        slip_cnt_next    = slip_cnt_reg;

        case (state_reg)
            SEARCH: begin
                slip_cnt_next = '0;
                run_cnt_next  = '0;
                if (in_is_token) begin
                    timeout_cnt_next = '0;
                    if (TOKEN_RUN <= 1) begin
                        state_next   = LOCKED;
                        run_cnt_next = RUN_FULL;
                    end else begin
                        state_next   = CONFIRM;
                        run_cnt_next = RUN_W'(1);
                    end
                end else if (timeout_cnt_reg >= TO_LAST) begin
                    state_next       = SLIP;
                    timeout_cnt_next = '0;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
                end
            end

            CONFIRM: begin
                timeout_cnt_next = '0;
                if (in_is_token) begin
                    if (run_cnt_reg >= RUN_LAST) begin
                        state_next   = LOCKED;
                        run_cnt_next = RUN_FULL;
                    end else begin
                        run_cnt_next = run_cnt_reg + RUN_W'(1);
                    end
                end else begin
                    state_next   = SLIP;
                    run_cnt_next = '0;
                end
            end

            SLIP: begin
                run_cnt_next     = '0;
                timeout_cnt_next = '0;
                if (slip_cnt_reg >= SLIP_LAST) begin
                    state_next    = SEARCH;
                    slip_cnt_next = '0;
                end else begin
                    slip_cnt_next = slip_cnt_reg + SLIP_W'(1);
                end
            end

            LOCKED: begin
                if (in_is_token) begin
                    timeout_cnt_next = '0;
                end else if (timeout_cnt_reg >= TO_LAST) begin
                    state_next       = SEARCH;
                    timeout_cnt_next = '0;
                    run_cnt_next     = '0;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
                end
            end

            default: state_next = SEARCH;
        endcase

        bitslip_next = (state_next == SLIP) && (state_reg != SLIP);
        locked_next  = (state_reg == LOCKED) && (state_next == LOCKED);
    end

    assign bus.data_out    = data_reg;
    assign bus.control_out = control_reg;
    assign bus.ve_out      = ve_reg;
    assign bus.valid_out   = locked_reg;
    assign bus.locked_out  = locked_reg;
    assign bus.bitslip_out = bitslip_reg;

endmodule
